// File: rtl/mem_req_sink.sv
// mem_req_sink: memory-side endpoint for the two-lane request master.
// Requests are queued in a small FIFO and then serviced one at a time.
// Each request waits a fixed number of cycles before it executes against
// an internal 64-bit word memory. A read returns both lanes with a
// single-cycle rvalid strobe.

module mem_req_sink #(
    parameter int MEM_WORDS   = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SERVICE_LAT = 2,
    parameter int VALID_W     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        addr [1:0],
    input  logic [VALID_W-1:0] valid,
    input  logic [63:0]        data1,
    input  logic [63:0]        data2,
    input  logic               wen,
    input  logic               ren,
    output logic               ready,
    output logic [63:0]        rdata1,
    output logic [63:0]        rdata2,
    output logic               rvalid,
    output logic               err
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       LAT_LOAD = (SERVICE_LAT == 0) ? 4'd0 : 4'(SERVICE_LAT - 1);

    // Only the word part of each address (addr[31:3]) is queued; the byte
    // offset bits never affect the memory access.
    typedef struct packed {
        logic        op;
        logic [1:0]  lanes;
        logic [28:0] word0;
        logic [28:0] word1;
        logic [63:0] d1;
        logic [63:0] d2;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EXEC
    } state_t;

    entry_t            fifo_mem [FIFO_DEPTH];
    entry_t            incoming;
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic              pop;
    logic              proto_err;

    state_t            state;
    state_t            state_next;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_cnt_next;

    logic [63:0]       mem [MEM_WORDS];
    logic [IDX_W-1:0]  idx0;
    logic [IDX_W-1:0]  idx1;
    logic              hit0;
    logic              hit1;
    logic              oor_err;
    logic              unused_bits;

    assign unused_bits = ^{addr[0][2:0], addr[1][2:0], valid};

    assign proto_err  = wen && ren;
    assign push       = (wen ^ ren) && ready;
    assign pop        = (state == S_EXEC);
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign incoming   = {wen, valid[1:0], addr[0][31:3], addr[1][31:3], data1, data2};
    assign head       = fifo_mem[rd_ptr];

    // A lane is executed only when it is enabled and no address bit sits
    // above the word-index field.
    assign idx0    = head.word0[IDX_W-1:0];
    assign idx1    = head.word1[IDX_W-1:0];
    assign hit0    = head.lanes[0] && (head.word0[28:IDX_W] == '0);
    assign hit1    = head.lanes[1] && (head.word1[28:IDX_W] == '0);
    assign oor_err = pop && ((head.lanes[0] && !hit0) || (head.lanes[1] && !hit1));

    // Request FIFO payload storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= incoming;
        end
    end

    // FIFO pointers, occupancy and registered ready; a pop in the same
    // cycle as a full FIFO does not open a slot until the next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            ready <= (count_next < DEPTH_C);
        end
    end

    // Service FSM state and latency counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state logic: every request passes through IDLE, then waits the
    // service latency, then spends one cycle in EXEC where it is popped.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    if (SERVICE_LAT == 0) begin
                        state_next = S_EXEC;
                    end else begin
                        state_next    = S_WAIT;
                        wait_cnt_next = LAT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = S_EXEC;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            S_EXEC: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Word memory; lane1 is written last, so it wins a same-word collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (pop && head.op) begin
            if (hit0) begin
                mem[idx0] <= head.d1;
            end
            if (hit1) begin
                mem[idx1] <= head.d2;
            end
        end
    end

    // Read response and error strobes; read data holds until the next read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata1 <= '0;
            rdata2 <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= pop && !head.op;
            err    <= proto_err || oor_err;
            if (pop && !head.op) begin
                rdata1 <= hit0 ? mem[idx0] : 64'd0;
                rdata2 <= hit1 ? mem[idx1] : 64'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_sink.sv
// Testbench for mem_req_sink: directed request sequence with a response
// scoreboard that records expected data and the expected arrival cycle.

module tb_mem_req_sink;

    localparam int LAT_MAIN = 2;
    localparam int LAT_MIN  = 0;

    typedef struct packed {
        logic [63:0] r1;
        logic [63:0] r2;
        int          due;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr [1:0];
    logic [2:0]  valid;
    logic [63:0] data1;
    logic [63:0] data2;
    logic        wen_main, ren_main, wen_min, ren_min;
    logic        ready_main, rvalid_main, err_main;
    logic        ready_min, rvalid_min, err_min;
    logic [63:0] rdata1_main, rdata2_main, rdata1_min, rdata2_min;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    int          last_due_main = 0;
    int          last_due_min = 0;
    resp_t       sb_main[$];
    resp_t       sb_min[$];
    bit          err_exp_main[int];
    bit          err_exp_min[int];
    logic [63:0] model_mem [2][16];
    bit          bp_acc [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    mem_req_sink #(
        .MEM_WORDS(16), .FIFO_DEPTH(4), .SERVICE_LAT(LAT_MAIN), .VALID_W(3)
    ) dut_main (
        .clk(clk), .reset(reset), .addr(addr), .valid(valid),
        .data1(data1), .data2(data2), .wen(wen_main), .ren(ren_main),
        .ready(ready_main), .rdata1(rdata1_main), .rdata2(rdata2_main),
        .rvalid(rvalid_main), .err(err_main)
    );

    mem_req_sink #(
        .MEM_WORDS(16), .FIFO_DEPTH(4), .SERVICE_LAT(LAT_MIN), .VALID_W(3)
    ) dut_min (
        .clk(clk), .reset(reset), .addr(addr), .valid(valid),
        .data1(data1), .data2(data2), .wen(wen_min), .ren(ren_min),
        .ready(ready_min), .rdata1(rdata1_min), .rdata2(rdata2_min),
        .rvalid(rvalid_min), .err(err_min)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_models();
        sb_main.delete();
        sb_min.delete();
        err_exp_main.delete();
        err_exp_min.delete();
        last_due_main = 0;
        last_due_min  = 0;
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 16; w++)
                model_mem[s][w] = 64'd0;
    endtask

    task automatic apply_stimulus(input bit sel, input bit w, input bit r,
                                  input logic [31:0] a0, input logic [31:0] a1,
                                  input logic [2:0] v, input logic [63:0] d1,
                                  input logic [63:0] d2, input bit exp_acc);
        int          acc;
        int          lat;
        int          due;
        logic [63:0] rd [2];
        logic [31:0] la [2];
        @(negedge clk);
        addr[0] = a0;
        addr[1] = a1;
        valid   = v;
        data1   = d1;
        data2   = d2;
        if (sel) begin
            wen_min = w;
            ren_min = r;
            check_output("ready_min", 64'(ready_min), 64'(exp_acc));
        end else begin
            wen_main = w;
            ren_main = r;
            check_output("ready_main", 64'(ready_main), 64'(exp_acc));
        end
        @(posedge clk);
        #1;
        acc = cyc;
        wen_main = 1'b0;
        ren_main = 1'b0;
        wen_min  = 1'b0;
        ren_min  = 1'b0;
        lat = sel ? LAT_MIN : LAT_MAIN;
        la[0] = a0;
        la[1] = a1;
        if (w && r) begin
            if (sel) err_exp_min[acc] = 1'b1;
            else     err_exp_main[acc] = 1'b1;
        end else if (exp_acc && (w || r)) begin
            due = acc + 2 + lat;
            if (sel) begin
                if (last_due_min + lat + 2 > due) due = last_due_min + lat + 2;
                last_due_min = due;
            end else begin
                if (last_due_main + lat + 2 > due) due = last_due_main + lat + 2;
                last_due_main = due;
            end
            for (int i = 0; i < 2; i++) begin
                rd[i] = 64'd0;
                if (v[i]) begin
                    if (la[i][31:7] != 25'd0) begin
                        if (sel) err_exp_min[due] = 1'b1;
                        else     err_exp_main[due] = 1'b1;
                    end else if (w) begin
                        model_mem[sel][la[i][6:3]] = (i == 0) ? d1 : d2;
                    end else begin
                        rd[i] = model_mem[sel][la[i][6:3]];
                    end
                end
            end
            if (r) begin
                if (sel) sb_min.push_back('{r1: rd[0], r2: rd[1], due: due});
                else     sb_main.push_back('{r1: rd[0], r2: rd[1], due: due});
            end
        end
    endtask

    // Scoreboard monitor for the SERVICE_LAT=2 instance.
    always @(negedge clk) begin : mon_main
        bit    exp_rv;
        resp_t e;
        if (mon_en) begin
            exp_rv = (sb_main.size() > 0) && (sb_main[0].due == cyc);
            check_output("rvalid_main", 64'(rvalid_main), 64'(exp_rv));
            if (exp_rv) begin
                e = sb_main.pop_front();
                check_output("rdata1_main", rdata1_main, e.r1);
                check_output("rdata2_main", rdata2_main, e.r2);
            end
            check_output("err_main", 64'(err_main), 64'(err_exp_main.exists(cyc)));
        end
    end

    // Scoreboard monitor for the SERVICE_LAT=0 instance.
    always @(negedge clk) begin : mon_min
        bit    exp_rv;
        resp_t e;
        if (mon_en) begin
            exp_rv = (sb_min.size() > 0) && (sb_min[0].due == cyc);
            check_output("rvalid_min", 64'(rvalid_min), 64'(exp_rv));
            if (exp_rv) begin
                e = sb_min.pop_front();
                check_output("rdata1_min", rdata1_min, e.r1);
                check_output("rdata2_min", rdata2_min, e.r2);
            end
            check_output("err_min", 64'(err_min), 64'(err_exp_min.exists(cyc)));
        end
    end

    initial begin
        reset    = 1'b0;
        addr[0]  = 32'd0;
        addr[1]  = 32'd0;
        valid    = 3'b000;
        data1    = 64'd0;
        data2    = 64'd0;
        wen_main = 1'b0;
        ren_main = 1'b0;
        wen_min  = 1'b0;
        ren_min  = 1'b0;
        clear_models();

        $display("[TB] reset values");
        repeat (3) @(negedge clk);
        check_output("rst_ready", 64'(ready_main), 64'd0);
        check_output("rst_rvalid", 64'(rvalid_main), 64'd0);
        check_output("rst_err", 64'(err_main), 64'd0);
        check_output("rst_rdata1", rdata1_main, 64'd0);
        check_output("rst_rdata2", rdata2_main, 64'd0);
        check_output("rst_ready_min", 64'(ready_min), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("ready_after_reset", 64'(ready_main), 64'd1);
        mon_en = 1'b1;

        $display("[TB] basic write/read");
        apply_stimulus(0, 1, 0, 32'h08, 32'h00, 3'b001, 64'hA5A5_0000_0000_0001, 64'h0, 1);
        idle(8);
        apply_stimulus(0, 0, 1, 32'h08, 32'h00, 3'b011, 64'h0, 64'h0, 1);
        idle(8);

        $display("[TB] protocol error");
        apply_stimulus(0, 1, 1, 32'h18, 32'h18, 3'b011, 64'h77, 64'h88, 1);
        idle(6);

        $display("[TB] out-of-range accesses");
        apply_stimulus(0, 1, 0, 32'h100, 32'h00, 3'b001, 64'hDEAD_BEEF_0000_0000, 64'h0, 1);
        idle(8);
        apply_stimulus(0, 0, 1, 32'h00, 32'h108, 3'b011, 64'h0, 64'h0, 1);
        idle(8);

        $display("[TB] lane collision");
        apply_stimulus(0, 1, 0, 32'h10, 32'h10, 3'b011, 64'd1, 64'd2, 1);
        idle(8);
        apply_stimulus(0, 0, 1, 32'h10, 32'h00, 3'b001, 64'h0, 64'h0, 1);
        idle(8);

        $display("[TB] backpressure");
        for (int i = 0; i < 6; i++)
            apply_stimulus(0, 1, 0, 32'h40 + 32'(8 * i), 32'h00, 3'b001,
                           64'h1000 + 64'(i), 64'h0, bp_acc[i]);
        idle(30);
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, 0, 1, 32'h40 + 32'(8 * i), 32'h00, 3'b001, 64'h0, 64'h0, 1);
            idle(5);
        end
        idle(4);

        $display("[TB] reset mid-operation");
        apply_stimulus(0, 0, 1, 32'h40, 32'h00, 3'b001, 64'h0, 64'h0, 1);
        apply_stimulus(0, 0, 1, 32'h48, 32'h00, 3'b001, 64'h0, 64'h0, 1);
        apply_stimulus(0, 0, 1, 32'h50, 32'h00, 3'b001, 64'h0, 64'h0, 1);
        reset = 1'b0;
        clear_models();
        @(negedge clk);
        check_output("midrst_ready", 64'(ready_main), 64'd0);
        check_output("midrst_rdata1", rdata1_main, 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("ready_after_midrst", 64'(ready_main), 64'd1);
        idle(12);
        apply_stimulus(0, 0, 1, 32'h40, 32'h48, 3'b011, 64'h0, 64'h0, 1);
        idle(8);

        $display("[TB] minimum latency");
        apply_stimulus(1, 1, 0, 32'h08, 32'h10, 3'b011, 64'h11, 64'h22, 1);
        idle(6);
        apply_stimulus(1, 0, 1, 32'h08, 32'h10, 3'b011, 64'h0, 64'h0, 1);
        apply_stimulus(1, 0, 1, 32'h10, 32'h08, 3'b011, 64'h0, 64'h0, 1);
        apply_stimulus(1, 0, 1, 32'h18, 32'h08, 3'b001, 64'h0, 64'h0, 1);
        apply_stimulus(1, 0, 1, 32'h08, 32'h00, 3'b010, 64'h0, 64'h0, 1);
        idle(12);

        check_output("sb_main_drained", 64'(sb_main.size()), 64'd0);
        check_output("sb_min_drained", 64'(sb_min.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_req_sink.md
# mem_req_sink

Downstream request sink for the bus master that drives two-lane `addr`/`data1`/`data2`/`wen`/`ren` requests and waits on `ready`. It accepts requests into a small FIFO, services them one at a time after a programmable service latency against an internal 64-bit word memory, and returns read data with a one-cycle `rvalid` pulse. It serves as the memory-side model and endpoint for that master in block-level and subsystem simulation.

## Interface
- `MEM_WORDS`, default 16: memory depth in 64-bit words (power of 2, ≥2).
- `FIFO_DEPTH`, default 4: request FIFO entries (power of 2, ≥2).
- `SERVICE_LAT`, default 2: wait cycles before each execute (0–15).
- `VALID_W`, default 3: width of the `valid` lane mask.

Ports, clock and reset first:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `addr`  in  [31:0] x2 (unpacked [1:0])  byte address per lane.
- `valid`  in  VALID_W  lane mask: bit0 = lane0 (`addr[0]`, `data1`), bit1 = lane1 (`addr[1]`, `data2`); higher bits ignored.
- `data1`, `data2`  in  64 each  write data for lanes 0 and 1.
- `wen`, `ren`  in  1 each  write and read request.
- `ready`  out  1  FIFO can accept a request.
- `rdata1`, `rdata2`  out  64 each  read data for lanes 0 and 1.
- `rvalid`  out  1  one-cycle read-response strobe.
- `err`  out  1  one-cycle error strobe.

## Operation
- **Accept.** An accept occurs on an edge where `(wen ^ ren) && ready`. The entry `{op, valid[1:0], addr[0], addr[1], data1, data2}` is pushed.
- **Protocol error.** `wen && ren` together is a protocol error: nothing is pushed and `err` pulses in the next cycle.
- **`ready`.** `ready` = FIFO count < FIFO_DEPTH. A same-cycle pop does not free space for a push when full.
- **Word index.** Lane word index = `addr[i][3 +: log2(MEM_WORDS)]`; `addr[i][2:0]` is ignored.
- **Out of range.** Any enabled lane with a nonzero address bit above the index field is out of range:
  - that lane is skipped;
  - `err` pulses in the cycle after execute;
  - the other lane still executes.
- **Service FSM.**
  - IDLE → WAIT when the FIFO is non-empty, loading the counter with SERVICE_LAT−1. If SERVICE_LAT = 0, IDLE → EXEC directly.
  - WAIT decrements the counter; at 0 → EXEC.
  - EXEC pops the head and executes → IDLE.
- **Write execute.** Each enabled, in-range lane writes its data word. If both lanes hit the same word, lane1 wins. `rvalid` stays 0.
- **Read execute.**
  - `rdataN` registers `mem[idx]` for enabled, in-range lanes, and 0 otherwise.
  - `rvalid` = 1 for one cycle, even when both lanes are masked.
  - `rdata1`/`rdata2` hold their value until the next read.
- **Memory.** Memory is reset to all zeros and has no external access.

## Timing
- **Reset values.** While `reset` = 0:
  - `ready`, `rvalid`, `err` = 0; `rdata1`, `rdata2` = 0;
  - FIFO empty, FSM in IDLE, memory zeroed.
  - `ready` rises the first cycle after reset deassertion.
- **Reset mid-operation.** In-flight and queued requests are discarded with no `rvalid` and no memory update.
- **Latency.** For a request accepted at edge N with the FIFO empty and FSM in IDLE:
  - FSM leaves IDLE at edge N+1;
  - the execute edge is N+1+SERVICE_LAT;
  - `rvalid` and the updated memory are visible from cycle N+2+SERVICE_LAT.
- **Throughput.** One request per SERVICE_LAT+2 cycles sustained. Back-to-back queued entries skip no IDLE cycle.
- **Read-after-write.** Requests execute in FIFO order, so a read queued after a write to the same word returns the new data.
- **Simultaneous errors.** `err` is the OR of the protocol error and the out-of-range error in the same cycle. It stays a single-cycle pulse per cycle.
- **Masked FIFO bits.** Masked lanes still occupy FIFO bits; their data is never used.

## Test plan
- **Basic write/read.** Write `addr[0]`=0x08, `data1`=0xA5A5_0000_0000_0001, `valid`=3'b001; then read 0x08 with `valid`=3'b011 → at cycle N+4 (SERVICE_LAT=2): `rvalid`=1, `rdata1`=0xA5A5_0000_0000_0001, `rdata2`=0.
- **Backpressure.** Hold `wen` for 6 consecutive cycles with FIFO_DEPTH=4 → `ready` drops after 4 accepts. Exactly 4 + the drained count are accepted, and memory matches the accepted requests only.
- **Errors.**
  - `wen`=`ren`=1 → `err` pulses for 1 cycle, with no push and no `rvalid`.
  - Write to `addr[0]`=0x100 → `err` pulses after execute, and memory is unchanged.
- **Lane collision.** Dual-lane write with both addresses 0x10, `data1`=1, `data2`=2; then read 0x10 → `rdata1`=2.
- **Reset mid-operation.** Queue 3 reads, then assert `reset` for 1 cycle before the first execute → no `rvalid` afterwards, and `ready`=1 on the first cycle after release.
- **Minimum latency.** SERVICE_LAT=0 with back-to-back reads → `rvalid` every 2nd cycle, first at cycle N+2.
